// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM word and handshake state, plus the arbiter request/state encodings.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        REQ_NONE   = 2'd0,
        REQ_IFETCH = 2'd1,
        REQ_DREAD  = 2'd2,
        REQ_DWRITE = 2'd3
    } arb_req_t;

    // Arbiter states as plain constants; BUSY is already taken by ramstate_t.
    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ARB_IDLE = 1'b0;
    localparam arb_state_t ARB_BUSY = 1'b1;

    function automatic logic req_is_data(input arb_req_t r);
        return (r == REQ_DREAD) || (r == REQ_DWRITE);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping; one-hot grant plus valid.
module rr_picker #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]                        req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
    output logic [N-1:0]                        gnt,
    output logic                                vld
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    int unsigned idx;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!vld && req[PW'(idx)]) begin
                gnt[PW'(idx)] = 1'b1;
                vld           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the icache and dcache of CPUS cores, one word per transaction.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned CPUS       = 2,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [CPUS-1:0]     iREN,
    input  word_t [CPUS-1:0]    iaddr,
    output logic [CPUS-1:0]     iwait,
    output word_t [CPUS-1:0]    iload,
    input  logic [CPUS-1:0]     dREN,
    input  logic [CPUS-1:0]     dWEN,
    input  word_t [CPUS-1:0]    daddr,
    input  word_t [CPUS-1:0]    dstore,
    output logic [CPUS-1:0]     dwait,
    output word_t [CPUS-1:0]    dload,
    output logic                ramREN,
    output logic                ramWEN,
    output word_t               ramaddr,
    output word_t               ramstore,
    input  word_t               ramload,
    input  ramstate_t           ramstate
);

    localparam int unsigned CW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int unsigned SW = $clog2(STARVE_LIM + 1);

    arb_state_t    state, state_n;
    arb_req_t      req, req_n;
    logic [CW-1:0] core, core_n;
    logic [CW-1:0] rr_ptr, rr_ptr_n;
    logic [SW-1:0] starve_cnt, starve_n;
    logic          ram_ren_n, ram_wen_n;
    word_t         ram_addr_n, ram_store_n;

    logic [CPUS-1:0] d_req, d_gnt, i_gnt;
    logic            d_vld, i_vld;
    logic [CW-1:0]   d_idx, i_idx;
    logic            live, done;

    function automatic logic [CW-1:0] oh2idx(input logic [CPUS-1:0] oh);
        oh2idx = '0;
        for (int unsigned i = 0; i < CPUS; i++) begin
            if (oh[i]) oh2idx = CW'(i);
        end
    endfunction

    assign d_req = dREN | dWEN;

    rr_picker #(.N(CPUS)) u_dpick (.req(d_req), .ptr(rr_ptr), .gnt(d_gnt), .vld(d_vld));
    rr_picker #(.N(CPUS)) u_ipick (.req(iREN),  .ptr(rr_ptr), .gnt(i_gnt), .vld(i_vld));

    assign d_idx = oh2idx(d_gnt);
    assign i_idx = oh2idx(i_gnt);

    // The granted core must still be asking, otherwise the transaction is abandoned.
    always_comb begin
        live = 1'b0;
        if (req == REQ_IFETCH)   live = iREN[core];
        else if (req_is_data(req)) live = d_req[core];
    end

    assign done = (state == ARB_BUSY) && live && (ramstate == ACCESS);

    // Completion handshake is visible only in the ACCESS cycle.
    always_comb begin
        iwait = '1;
        dwait = '1;
        iload = '0;
        dload = '0;
        if (done) begin
            if (req == REQ_IFETCH) begin
                iwait[core] = 1'b0;
                iload[core] = ramload;
            end else begin
                dwait[core] = 1'b0;
                if (req == REQ_DREAD) dload[core] = ramload;
            end
        end
    end

    always_comb begin
        state_n     = state;
        req_n       = req;
        core_n      = core;
        rr_ptr_n    = rr_ptr;
        starve_n    = starve_cnt;
        ram_ren_n   = ramREN;
        ram_wen_n   = ramWEN;
        ram_addr_n  = ramaddr;
        ram_store_n = ramstore;
        case (state)
            ARB_IDLE: begin
                if (i_vld && (starve_cnt == SW'(STARVE_LIM))) begin
                    state_n     = ARB_BUSY;
                    req_n       = REQ_IFETCH;
                    core_n      = i_idx;
                    ram_ren_n   = 1'b1;
                    ram_wen_n   = 1'b0;
                    ram_addr_n  = iaddr[i_idx];
                    ram_store_n = '0;
                    starve_n    = '0;
                end else if (d_vld) begin
                    state_n     = ARB_BUSY;
                    req_n       = dWEN[d_idx] ? REQ_DWRITE : REQ_DREAD;
                    core_n      = d_idx;
                    ram_ren_n   = !dWEN[d_idx];
                    ram_wen_n   = dWEN[d_idx];
                    ram_addr_n  = daddr[d_idx];
                    ram_store_n = dWEN[d_idx] ? dstore[d_idx] : '0;
                    if (i_vld && (starve_cnt != SW'(STARVE_LIM)))
                        starve_n = starve_cnt + SW'(1);
                end else if (i_vld) begin
                    state_n     = ARB_BUSY;
                    req_n       = REQ_IFETCH;
                    core_n      = i_idx;
                    ram_ren_n   = 1'b1;
                    ram_wen_n   = 1'b0;
                    ram_addr_n  = iaddr[i_idx];
                    ram_store_n = '0;
                    starve_n    = '0;
                end
            end
            ARB_BUSY: begin
                if (!live || (ramstate == ERROR) || (ramstate == ACCESS)) begin
                    state_n   = ARB_IDLE;
                    req_n     = REQ_NONE;
                    ram_ren_n = 1'b0;
                    ram_wen_n = 1'b0;
                end
                if (done)
                    rr_ptr_n = (32'(core) == CPUS - 1) ? '0 : core + CW'(1);
            end
            default: state_n = ARB_IDLE;
        endcase
        if (!(|iREN)) starve_n = '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= ARB_IDLE;
            req        <= REQ_NONE;
            core       <= '0;
            rr_ptr     <= '0;
            starve_cnt <= '0;
            ramREN     <= 1'b0;
            ramWEN     <= 1'b0;
            ramaddr    <= '0;
            ramstore   <= '0;
        end else begin
            state      <= state_n;
            req        <= req_n;
            core       <= core_n;
            rr_ptr     <= rr_ptr_n;
            starve_cnt <= starve_n;
            ramREN     <= ram_ren_n;
            ramWEN     <= ram_wen_n;
            ramaddr    <= ram_addr_n;
            ramstore   <= ram_store_n;
        end
    end

endmodule
